// File: rtl/hex_display_pkg.sv
// Shared types and the 7-segment lookup for the HEX display sequencer.
package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef struct packed {
        logic       blank;
        logic [3:0] val;
    } entry_t;

    // Active-low segments {dp, g..a}; the decimal point is never lit.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] i_val);
        logic [7:0] seg;
        case (i_val)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_encoder.sv
// Combinational hex-to-7-segment encoder; the single instance is time-shared by the scan FSM.
module seg7_encoder
    import hex_display_pkg::*;
(
    input  logic [3:0] i_val,
    output logic [7:0] o_seg
);

    assign o_seg = hex_to_seg(i_val);

endmodule

// File: rtl/hex_display_sequencer.sv
// Six-digit 7-segment refresh controller with a writer port and one shared encoder.
// Optional blinking of masked digits is enabled by defining HEX_BLINK_EN.
module hex_display_sequencer
    import hex_display_pkg::*;
#(
    parameter int NUM_DIGITS  = 6,
    parameter int REFRESH_DIV = 50000,
    parameter int BLINK_SCANS = 25
) (
    input  logic                  CLOCK_50,
    input  logic                  RESET_N,
    input  logic                  WR_VALID,
    output logic                  WR_READY,
    input  logic [2:0]            WR_IDX,
    input  logic [3:0]            WR_VAL,
    input  logic                  WR_BLANK,
    output logic                  WR_ERR,
    output logic                  BUSY,
`ifdef HEX_BLINK_EN
    input  logic [NUM_DIGITS-1:0] BLINK_MASK,
`endif
    output logic [7:0]            HEX0,
    output logic [7:0]            HEX1,
    output logic [7:0]            HEX2,
    output logic [7:0]            HEX3,
    output logic [7:0]            HEX4,
    output logic [7:0]            HEX5
);

    localparam int         PW   = $clog2(REFRESH_DIV);
    localparam logic [2:0] LAST = 3'(NUM_DIGITS - 1);

    if (NUM_DIGITS < 1 || NUM_DIGITS > 6 || REFRESH_DIV < 2 * NUM_DIGITS + 1 || BLINK_SCANS < 1)
    begin : g_bad_cfg
        $error("hex_display_sequencer: illegal parameter combination");
    end

    state_t        r_state;
    state_t        w_next;
    logic [PW-1:0] r_presc;
    logic          w_tick;
    logic          r_pending;
    logic [2:0]    r_idx;
    logic          w_last;
    logic          w_accept;
    logic          r_wr_err;
    entry_t        r_regs [NUM_DIGITS];
    entry_t        w_rd;
    entry_t        r_enc_in;
    logic [7:0]    w_seg;
    logic [7:0]    w_out;
    logic [7:0]    r_hex [6];

    assign w_tick   = (r_presc == PW'(REFRESH_DIV - 1));
    assign w_last   = (r_idx == LAST);
    assign WR_READY = (r_state != FETCH);
    assign BUSY     = (r_state != IDLE);
    assign WR_ERR   = r_wr_err;
    assign w_accept = WR_VALID && WR_READY;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_presc <= '0;
        end else if (w_tick) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_tick || r_pending) w_next = FETCH;
            FETCH:   w_next = WRITE;
            WRITE:   w_next = w_last ? IDLE : FETCH;
            default: w_next = IDLE;
        endcase
    end

    // A tick arriving mid-scan is remembered once; further ticks coalesce into it.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_pending <= 1'b0;
            r_idx     <= '0;
        end else if (r_state == IDLE) begin
            if (w_tick || r_pending) begin
                r_pending <= 1'b0;
                r_idx     <= '0;
            end
        end else begin
            if (w_tick) r_pending <= 1'b1;
            if (r_state == WRITE && !w_last) r_idx <= r_idx + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_wr_err <= 1'b0;
            for (int i = 0; i < NUM_DIGITS; i++) r_regs[i] <= '{blank: 1'b1, val: 4'h0};
        end else begin
            r_wr_err <= w_accept && (WR_IDX >= 3'(NUM_DIGITS));
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (w_accept && WR_IDX == 3'(i)) r_regs[i] <= '{blank: WR_BLANK, val: WR_VAL};
            end
        end
    end

    always_comb begin
        w_rd = '{blank: 1'b1, val: 4'h0};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_idx == 3'(i)) w_rd = r_regs[i];
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_enc_in <= '{blank: 1'b1, val: 4'h0};
        end else if (r_state == FETCH) begin
            r_enc_in <= w_rd;
        end
    end

    seg7_encoder u_enc (
        .i_val (r_enc_in.val),
        .o_seg (w_seg)
    );

`ifdef HEX_BLINK_EN
    localparam int BW = $clog2(BLINK_SCANS + 1);

    logic [BW-1:0] r_scan_cnt;
    logic          r_blink_off;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_scan_cnt  <= '0;
            r_blink_off <= 1'b0;
        end else if (r_state == WRITE && w_last) begin
            if (r_scan_cnt == BW'(BLINK_SCANS - 1)) begin
                r_scan_cnt  <= '0;
                r_blink_off <= ~r_blink_off;
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_out = r_enc_in.blank ? SEG_BLANK : w_seg;
        if (r_blink_off && BLINK_MASK[r_idx]) w_out = SEG_BLANK;
    end
`else
    always_comb begin
        w_out = r_enc_in.blank ? SEG_BLANK : w_seg;
    end
`endif

    // Digits beyond NUM_DIGITS are never written and keep their reset value.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 6; i++) r_hex[i] <= SEG_BLANK;
        end else if (r_state == WRITE) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (r_idx == 3'(i)) r_hex[i] <= w_out;
            end
        end
    end

    assign HEX0 = r_hex[0];
    assign HEX1 = r_hex[1];
    assign HEX2 = r_hex[2];
    assign HEX3 = r_hex[3];
    assign HEX4 = r_hex[4];
    assign HEX5 = r_hex[5];

endmodule

// File: tb/tb_hex_display_sequencer.sv
// Self-checking bench for hex_display_sequencer (blink section active when HEX_BLINK_EN is defined).
module tb_hex_display_sequencer;

    localparam int N   = 6;
    localparam int DIV = 40;
    localparam int BS  = 2;

    localparam logic [7:0] TBL [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    logic       clk = 1'b0;
    logic       rst_n;
    logic       wr_valid;
    logic       wr_ready;
    logic [2:0] wr_idx;
    logic [3:0] wr_val;
    logic       wr_blank;
    logic       wr_err;
    logic       busy;
    logic [7:0] hex0, hex1, hex2, hex3, hex4, hex5;
`ifdef HEX_BLINK_EN
    logic [N-1:0] blink_mask;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0] m_val   [6];
    logic       m_blank [6];

    always #5 clk = ~clk;

    hex_display_sequencer #(
        .NUM_DIGITS  (N),
        .REFRESH_DIV (DIV),
        .BLINK_SCANS (BS)
    ) dut (
        .CLOCK_50 (clk),
        .RESET_N  (rst_n),
        .WR_VALID (wr_valid),
        .WR_READY (wr_ready),
        .WR_IDX   (wr_idx),
        .WR_VAL   (wr_val),
        .WR_BLANK (wr_blank),
        .WR_ERR   (wr_err),
        .BUSY     (busy),
`ifdef HEX_BLINK_EN
        .BLINK_MASK (blink_mask),
`endif
        .HEX0 (hex0),
        .HEX1 (hex1),
        .HEX2 (hex2),
        .HEX3 (hex3),
        .HEX4 (hex4),
        .HEX5 (hex5)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] get_hex(input int k);
        case (k)
            0: return hex0;
            1: return hex1;
            2: return hex2;
            3: return hex3;
            4: return hex4;
            default: return hex5;
        endcase
    endfunction

    function automatic logic [7:0] exp_hex(input int k);
        if (k >= N || m_blank[k]) return 8'hFF;
        return TBL[m_val[k]];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 6; k++) begin
            m_val[k]   = 4'h0;
            m_blank[k] = 1'b1;
        end
    endtask

    task automatic check_all_hex(input string tag);
        for (int k = 0; k < 6; k++) chk($sformatf("%s_hex%0d", tag, k), 32'(get_hex(k)), 32'(exp_hex(k)));
    endtask

    // Counts negedges up to the first with BUSY high, then the number of BUSY-high negedges.
    task automatic wait_scan(output int gap, output int len);
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!busy && gap < 4 * DIV);
        len = 0;
        while (busy && len < 100) begin
            len++;
            @(negedge clk);
        end
    endtask

    task automatic do_write(input logic [2:0] idx, input logic [3:0] v, input logic b);
        int w;
        wr_idx   = idx;
        wr_val   = v;
        wr_blank = b;
        wr_valid = 1'b1;
        w = 0;
        while (!wr_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("wr_ready_wait", 32'(w < 50), 32'd1);
        @(negedge clk);
        wr_valid = 1'b0;
        chk("wr_err_pulse", 32'(wr_err), 32'(idx >= 3'(N)));
        if (idx < 3'(N)) begin
            m_val[idx]   = v;
            m_blank[idx] = b;
        end
        @(negedge clk);
        chk("wr_err_clear", 32'(wr_err), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, len, c, cyc;
        bit seen;

        rst_n    = 1'b0;
        wr_valid = 1'b0;
        wr_idx   = '0;
        wr_val   = '0;
        wr_blank = 1'b0;
`ifdef HEX_BLINK_EN
        blink_mask = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk);
        check_all_hex("reset");
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_err", 32'(wr_err), 32'd0);
        chk("reset_ready", 32'(wr_ready), 32'd1);

        // Two idle scans: first tick DIV cycles after release, each scan 2*N cycles.
        rst_n = 1'b1;
        wait_scan(gap, len);
        chk("scan1_gap", 32'(gap), 32'(DIV));
        chk("scan1_len", 32'(len), 32'(2 * N));
        check_all_hex("scan1");
        wait_scan(gap, len);
        chk("scan2_gap", 32'(gap), 32'(DIV - 2 * N));
        chk("scan2_len", 32'(len), 32'(2 * N));
        check_all_hex("scan2");

        do_write(3'd0, 4'h0, 1'b0);
        do_write(3'd1, 4'h1, 1'b0);
        do_write(3'd5, 4'hF, 1'b0);
        wait_scan(gap, len);
        chk("dir_len", 32'(len), 32'(2 * N));
        check_all_hex("dir");
        chk("dir_hex0_c0", 32'(hex0), 32'h0C0);
        chk("dir_hex5_8e", 32'(hex5), 32'h08E);

        do_write(3'd6, 4'h3, 1'b0);
        wait_scan(gap, len);
        check_all_hex("errwr");

        repeat (4) begin
            repeat (3) do_write(3'($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 3) == 0));
            wait_scan(gap, len);
            chk("rnd_len", 32'(len), 32'(2 * N));
            check_all_hex("rnd");
        end

        // WR_VALID held high across a scan start; a new random write is offered every cycle.
        c    = -1;
        seen = 1'b0;
        cyc  = 0;
        while (cyc < 150) begin
            wr_idx   = 3'($urandom_range(0, N - 1));
            wr_val   = 4'($urandom);
            wr_blank = ($urandom_range(0, 3) == 0);
            wr_valid = 1'b1;
            #1;
            if (busy) begin
                c++;
                seen = 1'b1;
                chk("held_ready_busy", 32'(wr_ready), 32'(c % 2));
            end else if (seen) begin
                break;
            end else begin
                chk("held_ready_idle", 32'(wr_ready), 32'd1);
            end
            if (wr_ready) begin
                m_val[wr_idx]   = wr_val;
                m_blank[wr_idx] = wr_blank;
            end
            @(negedge clk);
            cyc++;
        end
        wr_valid = 1'b0;
        chk("held_scan_seen", 32'(seen), 32'd1);
        chk("held_scan_len", 32'(c + 1), 32'(2 * N));
        wait_scan(gap, len);
        check_all_hex("held");

        // Reset asserted during the WRITE cycle of digit 3.
        gap = 0;
        do begin
            @(negedge clk);
            gap++;
        end while (!busy && gap < 4 * DIV);
        repeat (7) @(negedge clk);
        chk("midscan_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all_hex("async_rst");
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(wr_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_scan(gap, len);
        chk("resume_gap", 32'(gap), 32'(DIV));
        chk("resume_len", 32'(len), 32'(2 * N));
        check_all_hex("resume");

`ifdef HEX_BLINK_EN
        // Scan n (counted from reset) runs in the on phase when ((n-1)/BS) is even.
        blink_mask = 6'b000001;
        do_write(3'd0, 4'h8, 1'b0);
        for (int n = 2; n <= 7; n++) begin
            wait_scan(gap, len);
            chk($sformatf("blink_hex0_scan%0d", n), 32'(hex0),
                (((n - 1) / BS) % 2 == 0) ? 32'h080 : 32'h0FF);
            chk($sformatf("blink_hex1_scan%0d", n), 32'(hex1), 32'(exp_hex(1)));
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
